// File: rtl/floor_dispatcher.sv
// floor_dispatcher: request-to-service controller for one lift car.
// Latches hall/car buttons, tracks the halted floor, picks SCAN targets,
// times the door dwell and pulses button-lamp clears.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no motion, door closed, waiting for a pending request
// MOVE  | MOVE_REQ asserted, travelling toward TARGET_FLOOR along DIR_UP
// DOOR  | DOOR_OPEN asserted, dwell counter running at the current floor
module floor_dispatcher #(
    parameter int FLOORS       = 4,
    parameter int FLOOR_BITS   = 2,
    parameter int DWELL_CYCLES = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [FLOOR_BITS-1:0] CURRENT_FLOOR_IN,
    input  logic                  HALTED,
    input  logic [FLOORS-1:0]     FLOOR_REQUEST,
    output logic [FLOOR_BITS-1:0] CURRENT_FLOOR_OUT,
    output logic [FLOORS-1:0]     DESTINATIONS,
    output logic [FLOORS-1:0]     CLEAR_FLOOR_BUTTON,
    output logic [FLOOR_BITS-1:0] TARGET_FLOOR,
    output logic                  MOVE_REQ,
    output logic                  DIR_UP,
    output logic                  DOOR_OPEN
);

    localparam int CNT_BITS = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_BITS-1:0] DWELL_LAST = CNT_BITS'(DWELL_CYCLES - 1);
    // One extra bit so FLOORS == 2**FLOOR_BITS is still representable.
    localparam logic [FLOOR_BITS:0] FLOORS_W = (FLOOR_BITS + 1)'(FLOORS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_t;

    state_t                state, state_nx;
    logic [FLOOR_BITS-1:0] floor_q;
    logic [FLOOR_BITS-1:0] target_q, target_nx;
    logic [FLOORS-1:0]     pending_q;
    logic [FLOORS-1:0]     clr;
    logic [FLOORS-1:0]     floor_onehot;
    logic [CNT_BITS-1:0]   cnt_q, cnt_nx;
    logic                  dir_up_q, dir_nx;
    logic                  halted_q;
    logic                  door_first_q;
    logic                  floor_ok;
    logic                  halt_rise;
    logic                  above, below, here, req_here;
    logic [FLOOR_BITS-1:0] up_floor, dn_floor;

    // Halt edge qualified by an in-range floor index; out-of-range halts are ignored.
    always_comb begin
        floor_ok  = ({1'b0, CURRENT_FLOOR_IN} < FLOORS_W);
        halt_rise = HALTED & ~halted_q & floor_ok;
    end

    // Pending-set scan: nearest floor above and below the current floor.
    always_comb begin
        above    = 1'b0;
        below    = 1'b0;
        up_floor = floor_q;
        dn_floor = floor_q;
        // Scanning downward leaves the smallest floor above in up_floor.
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (FLOOR_BITS'(i) > floor_q)) begin
                above    = 1'b1;
                up_floor = FLOOR_BITS'(i);
            end
        end
        // Scanning upward leaves the largest floor below in dn_floor.
        for (int i = 0; i < FLOORS; i++) begin
            if (pending_q[i] && (FLOOR_BITS'(i) < floor_q)) begin
                below    = 1'b1;
                dn_floor = FLOOR_BITS'(i);
            end
        end
    end

    // One-hot of the current floor and the "request here" views.
    always_comb begin
        floor_onehot = '0;
        for (int i = 0; i < FLOORS; i++) begin
            floor_onehot[i] = (FLOOR_BITS'(i) == floor_q);
        end
        here     = |(pending_q & floor_onehot);
        req_here = |(FLOOR_REQUEST & floor_onehot);
    end

    // Next-state, direction, target, dwell counter and lamp-clear decode.
    always_comb begin
        state_nx  = state;
        dir_nx    = dir_up_q;
        target_nx = target_q;
        cnt_nx    = cnt_q;
        clr       = '0;
        unique case (state)
            S_IDLE: begin
                if (here) begin
                    state_nx = S_DOOR;
                    cnt_nx   = '0;
                end else if (above || below) begin
                    state_nx  = S_MOVE;
                    dir_nx    = above & (dir_up_q | ~below);
                    target_nx = dir_nx ? up_floor : dn_floor;
                end
            end
            S_MOVE: begin
                if (halt_rise) begin
                    state_nx = S_DOOR;
                    cnt_nx   = '0;
                end else if (dir_up_q && above) begin
                    target_nx = up_floor;
                end else if (!dir_up_q && below) begin
                    target_nx = dn_floor;
                end
            end
            S_DOOR: begin
                // A press at the open floor clears its lamp again and
                // holds the door; it never enters the pending set.
                if (door_first_q || req_here) begin
                    clr = floor_onehot;
                end
                if (req_here) begin
                    cnt_nx = '0;
                end else if (cnt_q == DWELL_LAST) begin
                    if (dir_up_q ? above : below) begin
                        state_nx  = S_MOVE;
                        target_nx = dir_up_q ? up_floor : dn_floor;
                    end else if (dir_up_q ? below : above) begin
                        state_nx  = S_MOVE;
                        dir_nx    = ~dir_up_q;
                        target_nx = dir_up_q ? dn_floor : up_floor;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    cnt_nx = cnt_q + 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= S_IDLE;
            floor_q      <= '0;
            pending_q    <= '0;
            target_q     <= '0;
            dir_up_q     <= 1'b1;
            cnt_q        <= '0;
            halted_q     <= 1'b0;
            door_first_q <= 1'b0;
        end else begin
            state        <= state_nx;
            target_q     <= target_nx;
            dir_up_q     <= dir_nx;
            cnt_q        <= cnt_nx;
            halted_q     <= HALTED;
            door_first_q <= (state != S_DOOR) && (state_nx == S_DOOR);
            // Clear wins over a same-cycle request for the same floor.
            pending_q    <= (pending_q | FLOOR_REQUEST) & ~clr;
            if (halt_rise) begin
                floor_q <= CURRENT_FLOOR_IN;
            end
        end
    end

    // Output mapping; MOVE_REQ and DOOR_OPEN decode disjoint states.
    always_comb begin
        CURRENT_FLOOR_OUT  = floor_q;
        DESTINATIONS       = pending_q;
        CLEAR_FLOOR_BUTTON = clr;
        TARGET_FLOOR       = target_q;
        MOVE_REQ           = (state == S_MOVE);
        DIR_UP             = dir_up_q;
        DOOR_OPEN          = (state == S_DOOR);
    end

endmodule

// File: tb/tb_floor_dispatcher.sv
// Testbench for floor_dispatcher: cycle vector table with a scoreboard queue,
// then directed sequences for SCAN order, door hold, out-of-range halt and reset.
module tb_floor_dispatcher;

    typedef struct packed {
        logic [3:0] dest;
        logic [3:0] clr;
        logic [1:0] tgt;
        logic       move;
        logic       dir;
        logic       door;
        logic [1:0] cfo;
    } outs_t;

    typedef struct {
        logic [3:0] req;
        logic       halt;
        logic [1:0] fin;
        outs_t      exp;
    } row_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [1:0] cfi = '0;
    logic       halted = 1'b0;
    logic [3:0] req = '0;
    logic [1:0] cfo;
    logic [3:0] dest, clr;
    logic [1:0] tgt;
    logic       move, dir, door;

    logic [1:0] cfi3 = '0;
    logic       halted3 = 1'b0;
    logic [2:0] req3 = '0;
    logic [1:0] cfo3, tgt3;
    logic [2:0] dest3, clr3;
    logic       move3, dir3, door3;

    int checks = 0;
    int errors = 0;
    int door_cycles = 0;
    int clr_pulses = 0;
    outs_t exp_q[$];
    row_t rows[14];

    floor_dispatcher #(.FLOORS(4), .FLOOR_BITS(2), .DWELL_CYCLES(8)) dut (
        .CLK(CLK), .RESET(RESET), .CURRENT_FLOOR_IN(cfi), .HALTED(halted),
        .FLOOR_REQUEST(req), .CURRENT_FLOOR_OUT(cfo), .DESTINATIONS(dest),
        .CLEAR_FLOOR_BUTTON(clr), .TARGET_FLOOR(tgt), .MOVE_REQ(move),
        .DIR_UP(dir), .DOOR_OPEN(door)
    );

    floor_dispatcher #(.FLOORS(3), .FLOOR_BITS(2), .DWELL_CYCLES(4)) dut3 (
        .CLK(CLK), .RESET(RESET), .CURRENT_FLOOR_IN(cfi3), .HALTED(halted3),
        .FLOOR_REQUEST(req3), .CURRENT_FLOOR_OUT(cfo3), .DESTINATIONS(dest3),
        .CLEAR_FLOOR_BUTTON(clr3), .TARGET_FLOOR(tgt3), .MOVE_REQ(move3),
        .DIR_UP(dir3), .DOOR_OPEN(door3)
    );

    always #5 CLK = ~CLK;

    // Door-open cycles and lamp-clear pulses observed mid-cycle.
    always @(negedge CLK) begin
        door_cycles <= door_cycles + int'(door);
        clr_pulses  <= clr_pulses + int'(clr != 4'b0000);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    function automatic row_t mk(input logic [3:0] r, input logic h, input logic [1:0] f,
                                input logic [3:0] e_dest, input logic [3:0] e_clr,
                                input logic [1:0] e_tgt, input logic e_move,
                                input logic e_dir, input logic e_door, input logic [1:0] e_cfo);
        row_t x;
        x.req  = r;
        x.halt = h;
        x.fin  = f;
        x.exp  = '{dest: e_dest, clr: e_clr, tgt: e_tgt, move: e_move,
                   dir: e_dir, door: e_door, cfo: e_cfo};
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Drive one cycle of main-DUT inputs and return just after the rising edge.
    task automatic cyc(input logic [3:0] r, input logic h, input logic [1:0] f);
        req    = r;
        halted = h;
        cfi    = f;
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_move(input string name);
        int n = 0;
        while (!move && n < 30) begin
            cyc(4'b0000, 1'b0, 2'd0);
            n++;
        end
        chk(name, 32'(move), 32'd1);
    endtask

    task automatic wait_closed(input string name);
        int n = 0;
        while (door && n < 30) begin
            cyc(4'b0000, 1'b0, 2'd0);
            n++;
        end
        chk(name, 32'(door), 32'd0);
    endtask

    initial begin
        int d0, c0;
        outs_t act, e;

        // Single up request from reset: floor 0 -> 2, 8-cycle dwell, back to idle.
        rows[0]  = mk(4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0, 0);
        rows[1]  = mk(4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0, 0);
        rows[2]  = mk(4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0, 0);
        rows[3]  = mk(4'b0100, 0, 0, 4'b0100, 4'b0000, 0, 0, 1, 0, 0);
        rows[4]  = mk(4'b0000, 0, 0, 4'b0100, 4'b0000, 2, 1, 1, 0, 0);
        rows[5]  = mk(4'b0000, 1, 2, 4'b0100, 4'b0100, 2, 0, 1, 1, 2);
        rows[6]  = mk(4'b0000, 1, 2, 4'b0000, 4'b0000, 2, 0, 1, 1, 2);
        for (int i = 7; i < 13; i++)
            rows[i] = mk(4'b0000, 0, 0, 4'b0000, 4'b0000, 2, 0, 1, 1, 2);
        rows[13] = mk(4'b0000, 0, 0, 4'b0000, 4'b0000, 2, 0, 1, 0, 2);

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_move", 32'(move), 0);
        chk("reset_dir", 32'(dir), 1);
        RESET = 1'b1;
        repeat (10) cyc(4'b0000, 1'b0, 2'd0);
        chk("idle_outputs", 32'({dest, clr, tgt, move, door, cfo}), 0);
        chk("idle_dir", 32'(dir), 1);

        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(rows[i].exp);
            cyc(rows[i].req, rows[i].halt, rows[i].fin);
            act = '{dest: dest, clr: clr, tgt: tgt, move: move, dir: dir, door: door, cfo: cfo};
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL row%0d: got dest=%b clr=%b tgt=%0d mv=%b dir=%b door=%b cfo=%0d expected dest=%b clr=%b tgt=%0d mv=%b dir=%b door=%b cfo=%0d",
                         i, act.dest, act.clr, act.tgt, act.move, act.dir, act.door, act.cfo,
                         e.dest, e.clr, e.tgt, e.move, e.dir, e.door, e.cfo);
            end
        end

        // Down to floor 1, then hold the door with a press at dwell count 5.
        cyc(4'b0010, 1'b0, 2'd0);
        cyc(4'b0000, 1'b0, 2'd0);
        chk("down_move", 32'(move), 1);
        chk("down_dir", 32'(dir), 0);
        chk("down_tgt", 32'(tgt), 1);
        d0 = door_cycles;
        c0 = clr_pulses;
        cyc(4'b0000, 1'b1, 2'd1);
        chk("f1_clear", 32'(clr), 32'b0010);
        chk("f1_cfo", 32'(cfo), 1);
        chk("f1_mutex", 32'(move & door), 0);
        repeat (5) cyc(4'b0000, 1'b0, 2'd0);
        cyc(4'b0010, 1'b0, 2'd0);
        wait_closed("hold_close");
        chk("hold_door_cycles", 32'(door_cycles - d0), 14);
        chk("hold_clr_pulses", 32'(clr_pulses - c0), 2);
        chk("hold_dest_bit1", 32'(dest[1]), 0);
        chk("hold_idle_move", 32'(move), 0);

        // SCAN: from floor 1 heading to 3, presses at 0 and 2.
        cyc(4'b1000, 1'b0, 2'd0);
        cyc(4'b0000, 1'b0, 2'd0);
        chk("scan_dir_up", 32'(dir), 1);
        chk("scan_tgt3", 32'(tgt), 3);
        cyc(4'b0101, 1'b0, 2'd0);
        cyc(4'b0000, 1'b0, 2'd0);
        chk("scan_retarget2", 32'(tgt), 2);
        chk("scan_dest", 32'(dest), 32'b1101);
        cyc(4'b0000, 1'b1, 2'd2);
        chk("scan_clr2", 32'(clr), 32'b0100);
        wait_move("scan_leave2");
        chk("scan_tgt3_again", 32'(tgt), 3);
        chk("scan_dir_keep", 32'(dir), 1);
        chk("scan_dest2", 32'(dest), 32'b1001);
        cyc(4'b0000, 1'b1, 2'd3);
        chk("scan_clr3", 32'(clr), 32'b1000);
        wait_move("scan_leave3");
        chk("scan_dir_flip", 32'(dir), 0);
        chk("scan_tgt0", 32'(tgt), 0);
        chk("scan_dest3", 32'(dest), 32'b0001);
        cyc(4'b0000, 1'b1, 2'd0);
        chk("scan_clr0", 32'(clr), 32'b0001);
        wait_closed("scan_close0");
        chk("scan_final_dest", 32'(dest), 0);
        chk("scan_final_move", 32'(move), 0);

        // Out-of-range halt on the 3-floor instance.
        req3 = 3'b010;
        cyc(4'b0000, 1'b0, 2'd0);
        req3 = 3'b000;
        cyc(4'b0000, 1'b0, 2'd0);
        chk("oor_move", 32'(move3), 1);
        chk("oor_tgt", 32'(tgt3), 1);
        halted3 = 1'b1;
        cfi3 = 2'd3;
        cyc(4'b0000, 1'b0, 2'd0);
        chk("oor_cfo_held", 32'(cfo3), 0);
        chk("oor_no_door", 32'(door3), 0);
        chk("oor_still_move", 32'(move3), 1);
        halted3 = 1'b0;
        cyc(4'b0000, 1'b0, 2'd0);
        halted3 = 1'b1;
        cfi3 = 2'd1;
        cyc(4'b0000, 1'b0, 2'd0);
        chk("oor_valid_door", 32'(door3), 1);
        chk("oor_valid_cfo", 32'(cfo3), 1);
        chk("oor_valid_clr", 32'(clr3), 32'b010);
        halted3 = 1'b0;

        // Reset while moving with pending 1010 (main car at floor 0).
        cyc(4'b1010, 1'b0, 2'd0);
        cyc(4'b0000, 1'b0, 2'd0);
        chk("rst_pre_move", 32'(move), 1);
        chk("rst_pre_dest", 32'(dest), 32'b1010);
        #2;
        RESET = 1'b0;
        #1;
        chk("rst_async_move", 32'(move), 0);
        chk("rst_async_dest", 32'(dest), 0);
        repeat (2) cyc(4'b0000, 1'b0, 2'd0);
        RESET = 1'b1;
        repeat (3) cyc(4'b0000, 1'b0, 2'd0);
        chk("rst_idle_move", 32'(move), 0);
        chk("rst_idle_door", 32'(door), 0);
        chk("rst_idle_dir", 32'(dir), 1);
        chk("rst_idle_dest", 32'(dest), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/floor_dispatcher.md
Name: floor_dispatcher

Overview:
- Parametrised successor to the floor/destination tracker; owns the full request-to-service loop for one car.
- Latches hall/car buttons into a pending set and tracks the car floor on each stop.
- Picks a direction and target with a SCAN policy, times the door dwell, and pulses button-lamp clears.
- Sits between the button/sensor inputs and the motor controller and display.

Parameters:
- FLOORS, 4, number of served floors; must be at least 2.
- FLOOR_BITS, 2, floor index width; 2^FLOOR_BITS >= FLOORS.
- DWELL_CYCLES, 8, door-open time in CLK cycles; must be at least 1.

Ports:
- CLK  in  1  system clock; all state is updated on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- CURRENT_FLOOR_IN  in  FLOOR_BITS  floor sensor index; valid while HALTED=1.
- HALTED  in  1  car stopped at a floor; a level signal, synchronous to CLK.
- FLOOR_REQUEST  in  FLOORS  button levels, one bit per floor; a bit may be held high.
- CURRENT_FLOOR_OUT  out  FLOOR_BITS  last floor where the car halted.
- DESTINATIONS  out  FLOORS  pending request set.
- CLEAR_FLOOR_BUTTON  out  FLOORS  one-hot, one-cycle lamp-clear pulse.
- TARGET_FLOOR  out  FLOOR_BITS  floor the motor controller must stop at.
- MOVE_REQ  out  1  car commanded to move toward TARGET_FLOOR.
- DIR_UP  out  1  travel direction: 1 = up, 0 = down.
- DOOR_OPEN  out  1  door command.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE; floor=0; pending=0.
  - TARGET_FLOOR=0, MOVE_REQ=0, DOOR_OPEN=0, CLEAR_FLOOR_BUTTON=0.
  - DIR_UP=1; dwell counter=0; halted_q=0.
  - Reset mid-move or mid-door discards all pending requests.
- HALTED edge detect: halt_rise = HALTED & ~halted_q, with halted_q registered each cycle.
- Floor latch:
  - On halt_rise, floor <= CURRENT_FLOOR_IN.
  - If CURRENT_FLOOR_IN >= FLOORS, the floor is held and the halt is ignored for FSM purposes.
- Pending update, every cycle: pending <= (pending | FLOOR_REQUEST) & ~clr, where clr is the CLEAR_FLOOR_BUTTON value issued that cycle.
  - Clear wins over a simultaneous request for the same floor.
  - A button still held afterwards re-sets the bit only while the FSM is not in DOOR at that floor.
- Latency: FLOOR_REQUEST at cycle t appears on DESTINATIONS at t+1.
- above = any pending bit > floor; below = any pending bit < floor; here = pending[floor].
- FSM states: IDLE, MOVE, DOOR.
- IDLE:
  - If here: go to DOOR.
  - Else if above or below: go to MOVE.
    - DIR_UP <= above & (DIR_UP | ~below).
    - TARGET_FLOOR <= nearest pending floor in that direction.
    - MOVE_REQ=1 from the next cycle.
  - Else stay in IDLE.
- MOVE:
  - MOVE_REQ=1.
  - Each cycle, TARGET_FLOOR <= nearest pending floor strictly beyond floor in the DIR_UP direction. Retargeting to a closer floor is allowed; the direction never reverses in MOVE.
  - On valid halt_rise: go to DOOR and drop MOVE_REQ in the same cycle the state changes.
- DOOR:
  - Entry cycle: CLEAR_FLOOR_BUTTON = one-hot(floor) for exactly one cycle; DOOR_OPEN=1; counter <= 0.
  - Each cycle, counter +1.
  - A FLOOR_REQUEST for the current floor during DOOR:
    - re-pulses CLEAR_FLOOR_BUTTON for that floor;
    - restarts the counter;
    - is never added to pending.
  - At counter == DWELL_CYCLES-1, DOOR_OPEN drops next cycle and the FSM re-evaluates:
    - pending in the current direction: go to MOVE, keeping the direction;
    - otherwise pending in the opposite direction: flip DIR_UP and go to MOVE;
    - otherwise go to IDLE.
- Halt edge in IDLE or DOOR: updates floor only, no FSM effect.
- MOVE_REQ and DOOR_OPEN are never high together.
- Counter width: $clog2(DWELL_CYCLES+1); no wrap is reachable.
- TARGET_FLOOR is meaningful only while MOVE_REQ=1; it holds its last value otherwise.

Test Plan:
- Reset and idle: FLOOR_REQUEST=0 for 10 cycles -> all outputs 0, DIR_UP=1, state IDLE.
- Single request up: floor 0, press bit 2 for 1 cycle.
  - DESTINATIONS=0100 next cycle; MOVE_REQ=1, TARGET_FLOOR=2, DIR_UP=1.
  - Then HALTED rises with CURRENT_FLOOR_IN=2 -> CLEAR_FLOOR_BUTTON=0100 for 1 cycle, DOOR_OPEN=1 for 8 cycles, then IDLE with DESTINATIONS=0.
- SCAN order: at floor 1 moving up to 3, press 0 and 2.
  - TARGET_FLOOR retargets to 2; floor 0 is served only after 2 and 3.
  - DIR_UP flips to 0 after the door at 3.
- Door hold: during DOOR at floor 1, press bit 1 at dwell count 5 -> second CLEAR pulse 0010, counter restarts, DOOR_OPEN total 14 cycles.
- Out-of-range and simultaneous events:
  - FLOORS=3, halt with CURRENT_FLOOR_IN=3 -> CURRENT_FLOOR_OUT unchanged, no DOOR.
  - A request and a clear for the same floor in the same cycle -> bit stays 0.
- Reset mid-move: assert RESET low while MOVE_REQ=1 with pending=1010 -> MOVE_REQ=0 and DESTINATIONS=0 immediately (asynchronous), IDLE after release.
